// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to stretch the stop phase to two bit cycles.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    par_en_q;
    logic                    tx_q;
    logic                    busy_q;

    // Parity type only shapes par_bit upstream; kept as a port for interface symmetry.
    logic unused_par_typ;
    assign unused_par_typ = PAR_TYP;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (DATA_VALID) begin
                        shift_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    cnt_q   <= '0;
                    state_q <= DATA;
                end
                DATA: begin
                    // The last data bit is already on the line once the counter reaches the end.
                    if (cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            tx_q    <= par_bit;
                            state_q <= PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
                STOP: begin
                    tx_q <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    state_q <= STOP2;
`else
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                STOP2: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: directed frames plus randomized frames
// compared bit-by-bit against a frame-level model of the serial line.
module tb_uart_tx_frame_ctrl;

    localparam int N = 8;

    logic         CLK;
    logic         RST;
    logic [N-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         par_bit;
    logic         TX_OUT;
    logic         Busy;

    int checks = 0;
    int errors = 0;
    bit holdValid = 0;

    uart_tx_frame_ctrl #(.DATA_WIDTH(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Upstream parity calculator: latches on an accepted request, result visible one edge later.
    always @(posedge CLK or negedge RST) begin
        if (!RST)
            par_bit <= 1'b0;
        else if (DATA_VALID && !Busy)
            par_bit <= (^P_DATA) ^ PAR_TYP;
    end

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Requests a word on the next edge; returns at the negedge right after acceptance.
    task automatic applyStimulus(input logic [N-1:0] w, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA     = w;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(negedge CLK);
    endtask

    // Expected line: start 0, data LSB first, optional parity, stop 1(s), then idle.
    task automatic checkFrame(input logic [N-1:0] w, input logic pe, input logic pt,
                              input bit glitch);
        logic exp[$];
        exp.push_back(1'b0);
        for (int i = 0; i < N; i++) exp.push_back(w[i]);
        if (pe) exp.push_back((^w) ^ pt);
        exp.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
        exp.push_back(1'b1);
`endif
        for (int i = 0; i < exp.size(); i++) begin
            if (i > 0) @(negedge CLK);
            checkOutput($sformatf("tx[%0d] word=%02h", i, w), TX_OUT, exp[i]);
            checkOutput($sformatf("busy[%0d] word=%02h", i, w), Busy, 1'b1);
            if (holdValid)
                DATA_VALID = 1'b1;
            else if (glitch) begin
                DATA_VALID = 1'($urandom_range(0, 1));
                P_DATA     = '1;
            end else
                DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        checkOutput($sformatf("idleBusy word=%02h", w), Busy, 1'b0);
        checkOutput($sformatf("idleTx word=%02h", w), TX_OUT, 1'b1);
        DATA_VALID = holdValid;
    endtask

    initial begin
        logic [N-1:0] w;
        logic         pe;
        logic         pt;
        bit           g;

        RST        = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        repeat (2) @(negedge CLK);
        checkOutput("resetTx", TX_OUT, 1'b1);
        checkOutput("resetBusy", Busy, 1'b0);
        RST = 1'b1;

        // Abandon a frame during data bit 3, then send one clean frame.
        applyStimulus(8'h99, 1'b1, 1'b0);
        checkOutput("midStart", TX_OUT, 1'b0);
        DATA_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("midBit3", TX_OUT, 1'b1);
        #2 RST = 1'b0;
        #1;
        checkOutput("asyncResetTx", TX_OUT, 1'b1);
        checkOutput("asyncResetBusy", Busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkFrame(8'h3C, 1'b0, 1'b0, 1'b0);

        $display("[TB] directed parity frames");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkFrame(8'hA5, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hA5, 1'b1, 1'b1);
        checkFrame(8'hA5, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkFrame(8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h81, 1'b0, 1'b0);
        checkFrame(8'h81, 1'b0, 1'b0, 1'b0);

        $display("[TB] back-to-back with DATA_VALID held high");
        holdValid = 1;
        applyStimulus(8'h55, 1'b1, 1'b0);
        P_DATA = 8'h0F;
        checkFrame(8'h55, 1'b1, 1'b0, 1'b0);
        holdValid = 0;
        @(negedge CLK);
        checkFrame(8'h0F, 1'b1, 1'b0, 1'b0);

        $display("[TB] mid-frame request pulses");
        applyStimulus(8'h33, 1'b1, 1'b1);
        checkFrame(8'h33, 1'b1, 1'b1, 1'b1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 16; f++) begin
            w  = N'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            g  = 1'($urandom_range(0, 1));
            applyStimulus(w, pe, pt);
            checkFrame(w, pe, pt, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
